// File: rtl/hb_pkg.sv
// Shared types, widths and helpers for the multi-channel hit counter.
package hb_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } scan_state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Active-high 7-segment image, bit order gfedcba.
  function automatic logic [SEG_W-1:0] seg7(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/hb_bcd_counter.sv
// One channel: enable synchroniser, falling-edge detect, BCD counter,
// sticky overflow and the dirty flag that requests a display update.
module hb_bcd_counter
  import hb_pkg::*;
#(
  parameter int unsigned NumDig     = 4,
  parameter bit          SatMode    = 1'b0,
  parameter int unsigned SyncStages = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tx_ena_n,
  input  logic                    clr,
  input  logic                    load,
  output logic [BCD_W*NumDig-1:0] count,
  output logic                    dirty,
  output logic                    ovf
);

  localparam int unsigned CW = BCD_W * NumDig;

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  hit_c;
  logic [CW-1:0]         inc_c;
  logic                  all_nines_c;

  assign hit_c = prev_q & ~sync_q[SyncStages-1];

  // Ripple BCD increment; a carry out of the top digit means all nines.
  always_comb begin
    inc_c       = count;
    all_nines_c = 1'b1;
    for (int unsigned k = 0; k < NumDig; k++) begin
      if (all_nines_c) begin
        if (count[BCD_W*k +: BCD_W] == 4'd9) begin
          inc_c[BCD_W*k +: BCD_W] = 4'd0;
        end else begin
          inc_c[BCD_W*k +: BCD_W] = count[BCD_W*k +: BCD_W] + 4'd1;
          all_nines_c             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      count  <= '0;
      ovf    <= 1'b0;
      dirty  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], tx_ena_n};
      prev_q <= sync_q[SyncStages-1];
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
        dirty <= 1'b1;
      end else if (hit_c && all_nines_c) begin
        ovf <= 1'b1;
        if (!SatMode) begin
          count <= '0;
          dirty <= 1'b1;
        end else if (load) begin
          dirty <= 1'b0;
        end
      end else if (hit_c) begin
        count <= inc_c;
        dirty <= 1'b1;
      end else if (load) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hb_multi_hit_counter.sv
// Multi-channel TX-enable hit counter with a round-robin scanner that
// streams changed counts as 7-segment words over valid/ready.
module hb_multi_hit_counter
  import hb_pkg::*;
#(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned NumDig     = 4,
  parameter bit          SatMode    = 1'b0,
  parameter int unsigned SyncStages = 2,
  localparam int unsigned ChW       = ch_w(NumCh)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NumCh-1:0]        i_tx_ena_n,
  input  logic                    i_clr,
  input  logic                    i_seg_ready,
  output logic [SEG_W*NumDig-1:0] o_seg_data,
  output logic [ChW-1:0]          o_seg_ch,
  output logic                    o_seg_valid,
  output logic [NumCh-1:0]        o_ovf
);

  localparam int unsigned CW = BCD_W * NumDig;

  logic [NumCh-1:0][CW-1:0] counts;
  logic [NumCh-1:0]         dirty;
  logic [NumCh-1:0]         load_c;
  scan_state_e              state;
  logic [ChW-1:0]           ptr;
  logic                     any_dirty_c;
  logic [ChW-1:0]           grant_c;
  logic [CW-1:0]            sel_count_c;
  int                       dist_c;
  int                       best_c;

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    hb_bcd_counter #(
      .NumDig    (NumDig),
      .SatMode   (SatMode),
      .SyncStages(SyncStages)
    ) u_cnt (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .tx_ena_n(i_tx_ena_n[g]),
      .clr     (i_clr),
      .load    (load_c[g]),
      .count   (counts[g]),
      .dirty   (dirty[g]),
      .ovf     (o_ovf[g])
    );
  end

  function automatic logic [SEG_W*NumDig-1:0] seg_word(input logic [CW-1:0] cnt);
    seg_word = '0;
    for (int unsigned k = 0; k < NumDig; k++) begin
      seg_word[SEG_W*k +: SEG_W] = seg7(cnt[BCD_W*k +: BCD_W]);
    end
  endfunction

  // Round robin: nearest dirty channel at or after the pointer wins.
  always_comb begin
    any_dirty_c = 1'b0;
    grant_c     = '0;
    sel_count_c = '0;
    load_c      = '0;
    dist_c      = 0;
    best_c      = int'(NumCh);
    for (int unsigned c = 0; c < NumCh; c++) begin
      dist_c = int'(c) + int'(NumCh) - int'(ptr);
      if (dist_c >= int'(NumCh)) dist_c = dist_c - int'(NumCh);
      if (dirty[c] && (dist_c < best_c)) begin
        best_c      = dist_c;
        grant_c     = ChW'(c);
        any_dirty_c = 1'b1;
      end
    end
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (ChW'(c) == grant_c) begin
        sel_count_c = counts[c];
        load_c[c]   = (state == IDLE) && any_dirty_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      o_seg_data  <= '0;
      o_seg_ch    <= '0;
      o_seg_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_dirty_c) begin
            o_seg_data  <= seg_word(sel_count_c);
            o_seg_ch    <= grant_c;
            o_seg_valid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (i_seg_ready) begin
            o_seg_valid <= 1'b0;
            ptr         <= (o_seg_ch == ChW'(NumCh - 1)) ? '0 : o_seg_ch + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_multi_hit_counter.sv
// Scoreboard bench: a 4x4-digit counter plus 1-digit wrap and saturate
// instances, checked against a decimal reference model.
module tb_hb_multi_hit_counter;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        ready;
  logic [3:0]  tx;
  logic [27:0] seg_data;
  logic [1:0]  seg_ch;
  logic        seg_valid;
  logic [3:0]  ovf;

  logic        stx;
  logic [6:0]  w_data, s_data;
  logic        w_ch, s_ch, w_valid, s_valid, w_ovf, s_ovf;

  typedef struct packed {
    logic [1:0]  ch;
    logic [27:0] data;
  } word_t;

  word_t      qm[$];
  logic [6:0] qw[$];
  logic [6:0] qs[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 1;
  int   cnt_m[4];
  bit   ovf_m[4];
  int   cnt_w, cnt_s;
  bit   ovf_w, ovf_s;

  bit          hold_m = 1'b0;
  logic [27:0] hold_d;
  logic [1:0]  hold_c;

  hb_multi_hit_counter #(.NumCh(4), .NumDig(4), .SatMode(1'b0), .SyncStages(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_ena_n(tx), .i_clr(clr), .i_seg_ready(ready),
    .o_seg_data(seg_data), .o_seg_ch(seg_ch), .o_seg_valid(seg_valid), .o_ovf(ovf));

  hb_multi_hit_counter #(.NumCh(1), .NumDig(1), .SatMode(1'b0), .SyncStages(2)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_ena_n(stx), .i_clr(1'b0), .i_seg_ready(1'b1),
    .o_seg_data(w_data), .o_seg_ch(w_ch), .o_seg_valid(w_valid), .o_ovf(w_ovf));

  hb_multi_hit_counter #(.NumCh(1), .NumDig(1), .SatMode(1'b1), .SyncStages(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_ena_n(stx), .i_clr(1'b0), .i_seg_ready(1'b1),
    .o_seg_data(s_data), .o_seg_ch(s_ch), .o_seg_valid(s_valid), .o_ovf(s_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual word=%0h required=no word", name, act);
  endtask

  // Decimal value to 7-segment image, least significant digit in bits [6:0].
  function automatic logic [27:0] img(input int v, input int nd);
    logic [6:0] tbl [10];
    int val;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    img = '0;
    val = v;
    for (int k = 0; k < nd; k++) begin
      img[7*k +: 7] = tbl[val % 10];
      val = val / 10;
    end
  endfunction

  task automatic push_main(input int ch);
    word_t w;
    w.ch   = 2'(ch);
    w.data = img(cnt_m[ch], 4);
    qm.push_back(w);
  endtask

  task automatic main_hit(input int ch);
    if (cnt_m[ch] == 9999) begin
      cnt_m[ch] = 0;
      ovf_m[ch] = 1'b1;
    end else begin
      cnt_m[ch]++;
    end
    push_main(ch);
  endtask

  task automatic small_hit();
    if (cnt_w == 9) ovf_w = 1'b1;
    cnt_w = (cnt_w + 1) % 10;
    qw.push_back(img(cnt_w, 1)[6:0]);
    if (cnt_s == 9) begin
      ovf_s = 1'b1;
    end else begin
      cnt_s++;
      qs.push_back(img(cnt_s, 1)[6:0]);
    end
  endtask

  function automatic logic [3:0] ovf_mask();
    ovf_mask = '0;
    for (int i = 0; i < 4; i++) ovf_mask = ovf_mask | (4'(ovf_m[i]) << i);
  endfunction

  // Model state after reset or clear: every channel reported once, in order.
  task automatic model_reset(input bit with_small);
    qm.delete();
    for (int i = 0; i < 4; i++) begin
      cnt_m[i] = 0;
      ovf_m[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) push_main(i);
    if (with_small) begin
      qw.delete();
      qs.delete();
      cnt_w = 0; cnt_s = 0; ovf_w = 1'b0; ovf_s = 1'b0;
      qw.push_back(img(0, 1)[6:0]);
      qs.push_back(img(0, 1)[6:0]);
    end
  endtask

  // ch < 0 pulses the shared enable of the one-digit instances.
  task automatic pulse(input int ch, input int lo, input int hi);
    logic [3:0] m;
    m = 4'b0001 << ((ch < 0) ? 0 : ch);
    @(posedge clk); #2;
    if (ch < 0) stx = 1'b0; else tx = tx & ~m;
    repeat (lo) @(posedge clk);
    #2;
    if (ch < 0) stx = 1'b1; else tx = tx | m;
    repeat (hi) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((qm.size() + qw.size() + qs.size()) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending_words", 32'(qm.size() + qw.size() + qs.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset();
    chk("rst_valid", 32'(seg_valid), 32'd0);
    chk("rst_data", 32'(seg_data), 32'd0);
    chk("rst_ch", 32'(seg_ch), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_small_valid", 32'({w_valid, s_valid}), 32'd0);
  endtask

  task automatic check_idle();
    repeat (10) begin
      @(negedge clk);
      chk("idle_valid", 32'(seg_valid), 32'd0);
    end
  endtask

  task automatic mon_main();
    word_t e;
    if (!rst_n) begin
      hold_m = 1'b0;
      return;
    end
    if (hold_m) begin
      chk("hold_valid", 32'(seg_valid), 32'd1);
      chk("hold_data", 32'(seg_data), 32'(hold_d));
      chk("hold_ch", 32'(seg_ch), 32'(hold_c));
    end
    if (seg_valid && ready) begin
      if (qm.size() == 0) begin
        unexpected("main_unexpected_word", {2'b0, seg_ch, seg_data});
      end else begin
        e = qm.pop_front();
        chk("main_word_ch", 32'(seg_ch), 32'(e.ch));
        chk("main_word_data", 32'(seg_data), 32'(e.data));
      end
    end
    hold_m = seg_valid && !ready;
    hold_d = seg_data;
    hold_c = seg_ch;
  endtask

  task automatic mon_small();
    logic [6:0] e;
    if (!rst_n) return;
    if (w_valid) begin
      if (qw.size() == 0) unexpected("wrap_unexpected_word", 32'(w_data));
      else begin
        e = qw.pop_front();
        chk("wrap_word_data", 32'(w_data), 32'(e));
        chk("wrap_word_ch", 32'(w_ch), 32'd0);
      end
    end
    if (s_valid) begin
      if (qs.size() == 0) unexpected("sat_unexpected_word", 32'(s_data));
      else begin
        e = qs.pop_front();
        chk("sat_word_data", 32'(s_data), 32'(e));
        chk("sat_word_ch", 32'(s_ch), 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_main();
      mon_small();
    end
  end

  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    rst_n = 1'b0;
    tx    = 4'hF;
    stx   = 1'b1;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset();

    // Reset release: every channel reported once with a zero count
    model_reset(1'b1);
    rst_n = 1'b1;
    drain();
    chk("init_ovf", 32'(ovf), 32'd0);
    check_idle();

    // Twelve clean hits on channel 1
    for (int i = 0; i < 12; i++) begin
      main_hit(1);
      pulse(1, 3, 3);
    end
    drain();

    // One-digit wrap and saturate: eleven hits
    for (int i = 0; i < 11; i++) begin
      small_hit();
      pulse(-1, 3, 3);
      drain();
      chk("wrap_ovf", 32'(w_ovf), 32'(ovf_w));
      chk("sat_ovf", 32'(s_ovf), 32'(ovf_s));
    end

    // Backpressure: ch2 then ch0 while downstream stalls
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    main_hit(2);
    pulse(2, 3, 3);
    main_hit(0);
    pulse(0, 3, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_valid", 32'(seg_valid), 32'd1);
    chk("stall_ch", 32'(seg_ch), 32'd2);
    rdy_mode = 1;
    drain();

    // Clear coinciding with a detected hit on channel 3 (count 5)
    for (int i = 0; i < 5; i++) begin
      main_hit(3);
      pulse(3, 3, 3);
    end
    drain();
    @(posedge clk); #2;
    tx[3] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b1;
    model_reset(1'b0);
    @(posedge clk); #2;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tx[3] = 1'b1;
    drain();
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Randomised single-channel hits under random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      int ch;
      ch = $urandom_range(0, 3);
      main_hit(ch);
      pulse(ch, $urandom_range(1, 4), $urandom_range(3, 6));
      drain();
      chk("rand_ovf", 32'(ovf), 32'(ovf_mask()));
    end

    // Reset asserted while a word is presented
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    main_hit(0);
    pulse(0, 3, 3);
    #1;
    chk("pre_rst_valid", 32'(seg_valid), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_drop_valid", 32'(seg_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    check_reset();
    rdy_mode = 1;
    model_reset(1'b1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drain();
    chk("post_rst_ovf", 32'(ovf), 32'd0);
    check_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hb_multi_hit_counter.md
Name: hb_multi_hit_counter

Overview:
Parametrised successor to the single-channel happy-birthday hit counter. It counts TX-enable assertions (falling edges of active-low enables) on NumCh independent channels. Each channel has its own NumDig-digit BCD counter with either wrap or saturate overflow handling. Changed counts are streamed out as 7-segment words, one channel per transfer, over a valid/ready interface to the display/logging stage.

Parameters:
NumCh, 4, number of independent TX-enable channels (1..16)
NumDig, 4, BCD digits per channel counter (1..8)
SatMode, 0, 0 = wrap to all zeros after all nines; 1 = saturate at all nines
SyncStages, 2, synchroniser depth on each i_tx_ena_n bit (>=2)

Ports:
i_clk  input  1  system clock, 10 kHz nominal
i_rst_n  input  1  reset, asynchronous, active-low
i_tx_ena_n  input  NumCh  active-low TX enables, asynchronous to i_clk
i_clr  input  1  synchronous clear of all counts and overflow flags
i_seg_ready  input  1  downstream accepts the current word
o_seg_data  output  7*NumDig  7-seg image of one channel; digit k in bits [7k+6:7k]
o_seg_ch  output  ChW  channel index of o_seg_data; ChW = max(1, clog2(NumCh))
o_seg_valid  output  1  o_seg_data/o_seg_ch valid
o_ovf  output  NumCh  sticky per-channel overflow flag

Behaviour:
- Reset (i_rst_n=0, async): all sync flops = 1 (idle), counts = 0, o_ovf = 0, o_seg_valid = 0, o_seg_data = 0, o_seg_ch = 0, round-robin pointer = 0, FSM = IDLE, dirty flags = all 1.
- After reset, all channels are reported once, in order ch0..chNumCh-1.
- Reset asserted mid-transfer drops o_seg_valid immediately; the word is lost.
- Hit detection: per-channel SyncStages-flop synchroniser followed by one history flop. hit = (prev==1 && cur==0).
- Hit latency: the count updates on the edge after the hit. Input fall to count update = SyncStages+1 rising edges.
- A held-low enable counts once. Glitches shorter than one clock are not guaranteed to be counted.
- BCD increment: digit 0 is least significant. A digit going from 9 to 0 carries into the next digit. Digits are always within 0..9.
- Overflow, count = all nines plus a hit:
  - SatMode=0: count becomes 0 and o_ovf[ch] is set.
  - SatMode=1: count is held at all nines, o_ovf[ch] is set, and dirty is not set.
- o_ovf bits clear only on reset or i_clr.
- i_clr: all counts = 0, o_ovf = 0, all dirty = 1.
  - A hit in the same cycle as i_clr is dropped (clear wins).
  - A transfer already presented completes unchanged.
- Dirty flag: set on every count change. It is cleared when that channel is loaded into the output register. A set in the same cycle as the clear wins.
- Scanner FSM:
  - IDLE:
    - If any dirty flag is set, grant the first dirty channel at or after the pointer (round robin).
    - Register the 7-seg encoding of its current count into o_seg_data and its index into o_seg_ch.
    - Set o_seg_valid=1, clear that channel's dirty flag, and go to SEND.
  - SEND:
    - Hold o_seg_data, o_seg_ch and o_seg_valid stable while i_seg_ready=0.
    - On i_seg_ready=1: o_seg_valid=0 next cycle, pointer = granted+1 (mod NumCh), go to IDLE.
  - Maximum throughput is one word per 2 cycles.
  - Hits during SEND update counts and dirty flags. They do not alter the presented word.
- 7-seg encoding: active-high, bit order gfedcba, bit 0 = a.
  - Digit codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - The all-zero image for NumDig=4 is 28'h7EFDFBF.

Decomposition:
- Package hb_pkg:
  - seg7 encode function (4-bit BCD to 7 bits)
  - scanner state enum {IDLE, SEND}
  - SEG_W = 7 localparam
  - ChW computation function
- Sub-module hb_bcd_counter: one generated instance per channel.
  - Contains the synchroniser, edge detect, BCD increment, overflow and dirty logic.
  - Parameters: NumDig, SatMode, SyncStages.
- The top level holds the round-robin scanner and the output register.

Test Plan:
1. Reset release, i_seg_ready=1, no hits -> four words with o_seg_ch 0,1,2,3 in order, each o_seg_data=28'h7EFDFBF; o_ovf=0; then o_seg_valid stays 0.
2. 12 clean falling edges on ch1 (pulse low 3 cycles, high 3 cycles) -> last ch1 word encodes BCD 0012: bits[6:0]=5B, bits[13:7]=06, upper digits=3F. Other channels emit nothing.
3. NumDig=1, SatMode=0, 11 hits on ch0 -> final count 1 (06), o_ovf[0]=1 from the 10th hit on. With SatMode=1, the same stimulus gives count held at 9 (6F), o_ovf[0]=1, and no word after the 9th.
4. Hits on ch2 then ch0 with i_seg_ready=0 for 20 cycles -> o_seg_data/o_seg_ch/o_seg_valid stable throughout. After ready rises, ch2 is delivered and then ch0 (round robin from pointer), each with its latest count.
5. i_clr pulsed in the same cycle as a detected hit on ch3 (count 5) -> ch3 count 0 with the hit dropped, o_ovf all 0, all four channels re-reported with 28'h7EFDFBF.
6. i_rst_n driven low while o_seg_valid=1 in SEND -> o_seg_valid=0 without a clock edge; after release, behaviour matches scenario 1.
